// File: rtl/output_stream_buffer_pkg.sv
// Shared types for the output stream buffer: frame-tracking states and the
// coordinate/last tag stored alongside each quantized word.
package output_stream_buffer_pkg;

    localparam int COORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        LAST_PENDING
    } osb_state_t;

    // Quantized word width is a module parameter, so the top wraps this tag
    // with its own q field to form a full entry.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] ch;
        logic               last;
    } entry_tag_t;

endpackage

// File: rtl/output_stream_buffer_sat_shift.sv
// Arithmetic right shift of a MAC accumulator followed by signed saturation
// to the output word width.
module sat_shift #(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 8
) (
    input  logic [ACC_WIDTH-1:0] din,
    output logic [OUT_WIDTH-1:0] dout
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        ACC_WIDTH'((longint'(1) <<< (OUT_WIDTH - 1)) - longint'(1));
    localparam logic signed [ACC_WIDTH-1:0] MIN_V =
        ACC_WIDTH'(-(longint'(1) <<< (OUT_WIDTH - 1)));

    logic signed [ACC_WIDTH-1:0] shifted;

    assign shifted = $signed(din) >>> SHIFT;

    always_comb begin
        dout = shifted[OUT_WIDTH-1:0];
        if (shifted > MAX_V) begin
            dout = MAX_V[OUT_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            dout = MIN_V[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/output_stream_buffer.sv
// Show-ahead FIFO between the conv controller and the downstream consumer;
// quantizes on push, tracks frame end and pulses frame_done on its pop.
//
// state        | meaning
// IDLE         | no element of the current frame received yet
// STREAM       | frame in progress, last element not yet pushed
// LAST_PENDING | last element is queued, waiting for it to be popped
module output_stream_buffer
    import output_stream_buffer_pkg::*;
#(
    parameter int DEPTH              = 8,
    parameter int ACC_WIDTH          = 32,
    parameter int OUT_WIDTH          = 16,
    parameter int SHIFT              = 8,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int AFULL_LEVEL        = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       arst_n_in,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [ACC_WIDTH-1:0]       in_data,
    input  logic [31:0]                in_x,
    input  logic [31:0]                in_y,
    input  logic [31:0]                in_ch,
    output logic                       almost_full,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_WIDTH-1:0]       out_data,
    output logic [31:0]                out_x,
    output logic [31:0]                out_y,
    output logic [31:0]                out_ch,
    output logic                       out_last,
    output logic                       frame_done,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] q;
        entry_tag_t           tag;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    entry_t            new_entry;
    logic [OUT_WIDTH-1:0] q_new;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              in_last;
    logic              push;
    logic              pop;
    osb_state_t        state;
    osb_state_t        next_state;

    sat_shift #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_sat_shift (
        .din  (in_data),
        .dout (q_new)
    );

    assign in_last = (in_x  == 32'(FEATURE_MAP_WIDTH - 1)) &&
                     (in_y  == 32'(FEATURE_MAP_HEIGHT - 1)) &&
                     (in_ch == 32'(OUTPUT_NB_CHANNELS - 1));

    assign new_entry = '{q: q_new, tag: '{x: in_x, y: in_y, ch: in_ch, last: in_last}};
    assign head      = mem[rd_ptr];

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push      = in_valid && ((count_q < CNT_W'(DEPTH)) || pop);

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state      <= IDLE;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state      <= IDLE;
        end else begin
            state <= next_state;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (in_valid && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    always_comb begin
        next_state = state;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (push) begin
                    next_state = in_last ? LAST_PENDING : STREAM;
                end
            end
            STREAM: begin
                if (push && in_last) begin
                    next_state = LAST_PENDING;
                end
            end
            LAST_PENDING: begin
                if (pop && head.tag.last) begin
                    next_state = IDLE;
                    frame_done = !clear;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Payload is forced to zero while empty so reset and flush present clean outputs.
    assign out_data    = out_valid ? head.q        : '0;
    assign out_x       = out_valid ? head.tag.x    : '0;
    assign out_y       = out_valid ? head.tag.y    : '0;
    assign out_ch      = out_valid ? head.tag.ch   : '0;
    assign out_last    = out_valid && head.tag.last;
    assign almost_full = (count_q >= CNT_W'(AFULL_LEVEL));
    assign overflow    = overflow_q;
    assign count       = count_q;

endmodule

// File: tb/tb_output_stream_buffer.sv
// Randomized and directed checks of output_stream_buffer against a queue-based
// reference model on a 2x2x2 frame.
module tb_output_stream_buffer;

    localparam int DEPTH = 8;
    localparam int SHIFT = 8;
    localparam int FMW   = 2;
    localparam int FMH   = 2;
    localparam int NCH   = 2;
    localparam int AFULL = DEPTH - 2;

    logic        clk = 1'b0;
    logic        arst_n_in;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic [31:0] in_x, in_y, in_ch;
    logic        almost_full;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [31:0] out_x, out_y, out_ch;
    logic        out_last;
    logic        frame_done;
    logic        overflow;
    logic [3:0]  count;

    always #5 clk = ~clk;

    output_stream_buffer #(
        .DEPTH              (DEPTH),
        .ACC_WIDTH          (32),
        .OUT_WIDTH          (16),
        .SHIFT              (SHIFT),
        .FEATURE_MAP_WIDTH  (FMW),
        .FEATURE_MAP_HEIGHT (FMH),
        .OUTPUT_NB_CHANNELS (NCH),
        .AFULL_LEVEL        (AFULL)
    ) dut (
        .clk         (clk),
        .arst_n_in   (arst_n_in),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_ch       (in_ch),
        .almost_full (almost_full),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_ch      (out_ch),
        .out_last    (out_last),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .count       (count)
    );

    typedef struct {
        logic [15:0] q;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
        bit          last;
    } m_entry_t;

    m_entry_t mq[$];
    bit       m_ovf;
    bit       m_pend;
    int       n_chk = 0;
    int       n_pass = 0;
    int       fd_seen = 0;
    int       last_seen = 0;

    logic [31:0] qv [4] = '{32'h0001_2345, 32'h7FFF_FFFF, 32'hFF00_0000, 32'hFFFF_FF00};
    logic [15:0] qe [4] = '{16'h0123, 16'h7FFF, 16'h8000, 16'hFFFF};

    function automatic logic [15:0] quant(input logic [31:0] d);
        longint v;
        v = longint'($signed(d));
        v = v >>> SHIFT;
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_pend = 1'b0;
    endtask

    function automatic logic [31:0] rnd_data();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 2))
            0:       return r;
            1:       return {{8{r[23]}}, r[23:0]};
            default: return {{4{r[27]}}, r[27:0]};
        endcase
    endfunction

    // One clock cycle: drive at negedge, compare outputs, then advance the model.
    task automatic step(input bit v, input logic [31:0] d, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] ch,
                        input bit rdy, input bit clr);
        bit       e_valid, e_pop, e_push, e_fd;
        m_entry_t h;
        m_entry_t ne;
        @(negedge clk);
        in_valid = v; in_data = d; in_x = x; in_y = y; in_ch = ch;
        out_ready = rdy; clear = clr;
        #1;
        e_valid = (mq.size() != 0);
        if (e_valid) h = mq[0];
        else h = '{q: 16'h0, x: 32'h0, y: 32'h0, ch: 32'h0, last: 1'b0};
        e_pop  = e_valid && rdy;
        e_push = v && ((mq.size() < DEPTH) || e_pop);
        e_fd   = !clr && e_pop && h.last && m_pend;
        chk("out_valid",   64'(out_valid),   64'(e_valid));
        chk("out_data",    64'(out_data),    64'(h.q));
        chk("out_x",       64'(out_x),       64'(h.x));
        chk("out_y",       64'(out_y),       64'(h.y));
        chk("out_ch",      64'(out_ch),      64'(h.ch));
        chk("out_last",    64'(out_last),    64'(h.last));
        chk("count",       64'(count),       64'(mq.size()));
        chk("almost_full", 64'(almost_full), 64'(mq.size() >= AFULL));
        chk("overflow",    64'(overflow),    64'(m_ovf));
        chk("frame_done",  64'(frame_done),  64'(e_fd));
        if (frame_done) fd_seen++;
        if (out_valid && out_ready && out_last) last_seen++;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (e_push) begin
                ne.q    = quant(d);
                ne.x    = x;
                ne.y    = y;
                ne.ch   = ch;
                ne.last = (x == FMW - 1) && (y == FMH - 1) && (ch == NCH - 1);
                mq.push_back(ne);
                if (ne.last) m_pend = 1'b1;
            end
            if (e_fd) m_pend = 1'b0;
            if (v && !e_push) m_ovf = 1'b1;
        end
    endtask

    task automatic chk_idle_outputs(input string pfx);
        chk({pfx, "_out_valid"},   64'(out_valid),   64'd0);
        chk({pfx, "_count"},       64'(count),       64'd0);
        chk({pfx, "_almost_full"}, 64'(almost_full), 64'd0);
        chk({pfx, "_frame_done"},  64'(frame_done),  64'd0);
        chk({pfx, "_overflow"},    64'(overflow),    64'd0);
        chk({pfx, "_out_last"},    64'(out_last),    64'd0);
        chk({pfx, "_out_data"},    64'(out_data),    64'd0);
        chk({pfx, "_out_xyc"},     64'(out_x | out_y | out_ch), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int pct;
        arst_n_in = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        in_x = '0; in_y = '0; in_ch = '0; out_ready = 1'b0;
        model_reset();
        #12;
        chk_idle_outputs("reset");
        @(negedge clk);
        arst_n_in = 1'b1;

        // quantization corner values
        for (int i = 0; i < 4; i++) begin
            step(1'b1, qv[i], 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            #1 chk("quant_vec", 64'(out_data), 64'(qe[i]));
            step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        end

        // fill to full and overflow
        for (int i = 0; i < 7; i++) begin
            step(1'b1, rnd_data(), 32'd0, 32'd0, 32'(i), 1'b0, 1'b0);
            if (i == 4) begin
                #1 chk("af_at_5", 64'(almost_full), 64'd0);
            end
            if (i == 5) begin
                #1 chk("af_at_6", 64'(almost_full), 64'd1);
                chk("count_6", 64'(count), 64'd6);
            end
        end
        #1 chk("count_7", 64'(count), 64'd7);
        step(1'b1, rnd_data(), 32'd0, 32'd0, 32'd7, 1'b0, 1'b0);
        #1 chk("count_8", 64'(count), 64'd8);
        step(1'b1, rnd_data(), 32'd0, 32'd0, 32'd8, 1'b0, 1'b0);
        #1 chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd8);
        chk("ovf_head_ch", 64'(out_ch), 64'd0);

        // flush with clear while push and pop are requested
        repeat (3) step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1 chk("pre_clear_count", 64'(count), 64'd5);
        step(1'b1, rnd_data(), 32'd0, 32'd0, 32'd9, 1'b1, 1'b1);
        #1 chk_idle_outputs("clear");

        // simultaneous push and pop at full
        for (int i = 0; i < 8; i++) step(1'b1, rnd_data(), 32'd0, 32'd0, 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, rnd_data(), 32'd0, 32'd0, 32'(8 + i), 1'b1, 1'b0);
        #1 chk("pp_count", 64'(count), 64'd8);
        chk("pp_overflow", 64'(overflow), 64'd0);
        chk("pp_head_ch", 64'(out_ch), 64'd20);

        // asynchronous reset mid-frame
        repeat (3) step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        #1 chk("pre_rst_count", 64'(count), 64'd5);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 arst_n_in = 1'b0;
        #1 chk_idle_outputs("async_rst");
        model_reset();
        @(negedge clk);
        arst_n_in = 1'b1;

        // two complete frames, last element (1,1,1) pushed last
        fd_seen = 0; last_seen = 0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 8; i++)
                step(1'b1, rnd_data(), 32'((i >> 2) & 1), 32'((i >> 1) & 1), 32'(i & 1), 1'b1, 1'b0);
            repeat (3) step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
            chk("frame_done_pulses", 64'(fd_seen), 64'(f + 1));
            chk("out_last_pops", 64'(last_seen), 64'(f + 1));
        end

        // randomized traffic with varying downstream throughput
        pct = 50;
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) pct = (i / 100 % 3 == 0) ? 20 : ((i / 100 % 3 == 1) ? 90 : 50);
            step($urandom_range(0, 3) != 0, rnd_data(),
                 32'($urandom_range(0, 1)), 32'($urandom_range(0, 1)), 32'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < pct, $urandom_range(0, 59) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
